// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, then payload MSB-first, one bit per clock.
// Optional even-parity bit after the payload when SEQ_FRAME_TX_PARITY_EN is defined.
// Every output, including PS_out, comes straight from a flop.
module seq_frame_tx #(
  parameter int unsigned          WIDTH    = 8,
  parameter int unsigned          SYNC_LEN = 3,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       PS_out
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSync   = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StDone   = 3'd4
  } state_e;

  localparam int unsigned MaxLen = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
  localparam int unsigned CntW   = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  state_e              state_q;
  logic [WIDTH-1:0]    shreg_q;
  logic [SYNC_LEN-1:0] sync_q;   // remaining sync bits, next one at the MSB
  logic [CntW-1:0]     cnt_q;    // cycles left in the current phase, minus one
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic                par_q;    // parity taken at capture, since the shift destroys the payload
`endif

  assign PS_out = state_q;

  // Frame sequencer; each branch also sets the outputs for the cycle it enters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      sync_q     <= '0;
      cnt_q      <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          if (start) begin
            state_q    <= StSync;
            shreg_q    <= data_in;
            sync_q     <= SYNC_PAT << 1;
            cnt_q      <= CntW'(SYNC_LEN - 1);
            dout       <= SYNC_PAT[SYNC_LEN-1];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q      <= ^data_in;
`endif
          end
        end

        StSync: begin
          if (cnt_q == '0) begin
            state_q <= StData;
            cnt_q   <= CntW'(WIDTH - 1);
            dout    <= shreg_q[WIDTH-1];
            shreg_q <= shreg_q << 1;
          end else begin
            cnt_q  <= cnt_q - CntW'(1);
            dout   <= sync_q[SYNC_LEN-1];
            sync_q <= sync_q << 1;
          end
        end

        StData: begin
          if (cnt_q == '0) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
            state_q <= StParity;
            dout    <= par_q;
`else
            state_q    <= StDone;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            cnt_q   <= cnt_q - CntW'(1);
            dout    <= shreg_q[WIDTH-1];
            shreg_q <= shreg_q << 1;
          end
        end

`ifdef SEQ_FRAME_TX_PARITY_EN
        StParity: begin
          state_q    <= StDone;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
`endif

        StDone: begin
          state_q <= StIdle;
          done    <= 1'b0;
        end

        // Unused codes (and PARITY when disabled) fall back to a quiet IDLE.
        default: begin
          state_q    <= StIdle;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
